// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction fetch unit. Issues word reads into a
// fixed-latency memory pipeline ahead of decode. It buffers the returned
// instructions in a small prefetch FIFO and hands them to decode over a
// valid/ready handshake. A redirect flushes both the FIFO and every
// in-flight fetch.
module fetch_queue #(
    parameter int                ADDR_WIDTH  = 10,
    parameter int                XLEN        = 64,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                MEM_LATENCY = 1,
    parameter logic [XLEN-1:0]   RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr,
    output logic [XLEN-1:0]               instr_pc,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_re,
    input  logic [63:0]                   mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [XLEN-1:0]        r_fetchPc;
    logic [MEM_LATENCY-1:0] r_flValid;
    logic [XLEN-1:0]        r_flPc [MEM_LATENCY];
    logic [31:0]            r_fifoInstr [FIFO_DEPTH];
    logic [XLEN-1:0]        r_fifoPc [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wrPtr;
    logic [PTR_W-1:0]       r_rdPtr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_pop;
    logic                   w_retire;
    logic                   w_issue;
    logic [SUM_W-1:0]       w_inflight;
    logic [SUM_W-1:0]       w_credit;
    logic [31:0]            w_respInstr;
    logic                   w_unused;

    // The two low bits of a redirect target are forced to zero, so they are dropped.
    assign w_unused = ^redirect_pc[1:0];

    // The head is available whenever the FIFO holds anything. A redirect overrides the pop.
    assign instr_valid = (r_count != '0);
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign w_retire    = r_flValid[MEM_LATENCY-1] && !redirect_valid;

    // The oldest in-flight fetch picks its half of the 64-bit word using pc bit 2.
    assign w_respInstr = r_flPc[MEM_LATENCY-1][2] ? mem_rdata[63:32] : mem_rdata[31:0];

    // Count the in-flight fetches that are not retiring this cycle.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LATENCY - 1; i++) begin
            w_inflight = w_inflight + SUM_W'(r_flValid[i]);
        end
    end

    // Credit check: queued + outstanding + an unpopped retiring entry must stay below depth.
    always_comb begin
        w_credit = SUM_W'(r_count) + w_inflight + SUM_W'(w_retire && !w_pop);
        w_issue  = !redirect_valid && (w_credit < SUM_W'(FIFO_DEPTH));
    end

    // The memory sees no request while reset is held.
    assign mem_re      = w_issue && rst_n;
    assign mem_addr    = r_fetchPc[ADDR_WIDTH+2:3];
    assign instr       = r_fifoInstr[r_rdPtr];
    assign instr_pc    = r_fifoPc[r_rdPtr];
    assign queue_count = r_count;

    // Fetch PC: a redirect loads the word-aligned target; otherwise it advances on each issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchPc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetchPc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_issue) begin
            r_fetchPc <= r_fetchPc + XLEN'(4);
        end
    end

    // In-flight pipeline: shift {valid, pc} one stage per cycle; a redirect kills every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flValid <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_flPc[i] <= '0;
            end
        end else begin
            r_flValid[0] <= w_issue;
            r_flPc[0]    <= r_fetchPc;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_flValid[i] <= r_flValid[i-1] && !redirect_valid;
                r_flPc[i]    <= r_flPc[i-1];
            end
        end
    end

    // FIFO storage: a retiring response is written at the tail. Entries are zeroed on reset so the head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifoInstr[i] <= '0;
                r_fifoPc[i]    <= '0;
            end
        end else if (w_retire) begin
            r_fifoInstr[r_wrPtr] <= w_respInstr;
            r_fifoPc[r_wrPtr]    <= r_flPc[MEM_LATENCY-1];
        end
    end

    // FIFO pointers and occupancy: binary pointers wrap naturally; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_retire) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_retire) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed testbench for fetch_queue. Instance A uses a
// memory latency of 1 and instance B uses a latency of 3. Each instance
// gets its own behavioural memory. Every expected value is hand-derived
// or computed from the memory contents.
module tb_fetch_queue;

    logic        clk;
    logic        rstN;

    logic        redirectValid;
    logic [63:0] redirectPc;
    logic        instrReady;
    logic        instrValid;
    logic [31:0] instrA;
    logic [63:0] instrPc;
    logic [9:0]  memAddr;
    logic        memRe;
    logic [63:0] memRdata;
    logic [2:0]  queueCount;

    logic        redirectValidB;
    logic [63:0] redirectPcB;
    logic        instrReadyB;
    logic        instrValidB;
    logic [31:0] instrB;
    logic [63:0] instrPcB;
    logic [9:0]  memAddrB;
    logic        memReB;
    logic [63:0] memRdataB;
    logic [2:0]  queueCountB;

    logic [63:0] pipeA;
    logic [63:0] pipeB [3];

    int compared;
    int mismatched;

    fetch_queue #(.ADDR_WIDTH(10), .XLEN(64), .FIFO_DEPTH(4), .MEM_LATENCY(1), .RESET_PC(64'h0)) dutA (
        .clk(clk), .rst_n(rstN),
        .redirect_valid(redirectValid), .redirect_pc(redirectPc),
        .instr_valid(instrValid), .instr_ready(instrReady),
        .instr(instrA), .instr_pc(instrPc),
        .mem_addr(memAddr), .mem_re(memRe), .mem_rdata(memRdata),
        .queue_count(queueCount)
    );

    fetch_queue #(.ADDR_WIDTH(10), .XLEN(64), .FIFO_DEPTH(4), .MEM_LATENCY(3), .RESET_PC(64'h0)) dutB (
        .clk(clk), .rst_n(rstN),
        .redirect_valid(redirectValidB), .redirect_pc(redirectPcB),
        .instr_valid(instrValidB), .instr_ready(instrReadyB),
        .instr(instrB), .instr_pc(instrPcB),
        .mem_addr(memAddrB), .mem_re(memReB), .mem_rdata(memRdataB),
        .queue_count(queueCountB)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: words 0 and 1 are fixed; the rest encode their own byte address.
    function automatic logic [63:0] memWord(input logic [9:0] a);
        logic [31:0] lo;
        logic [31:0] hi;
        if (a == 10'd0) return 64'h00200093_00100093;
        if (a == 10'd1) return 64'h00400193_00300113;
        lo = 32'hA000_0000 | {19'd0, a, 3'b000};
        hi = 32'hA000_0000 | {19'd0, a, 3'b100};
        return {hi, lo};
    endfunction

    // Expected instruction at a byte PC; the word address wraps at 10 bits.
    function automatic logic [31:0] expInstr(input logic [63:0] pc);
        logic [63:0] w;
        w = memWord(pc[12:3]);
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    // Memory with 1-cycle read latency for instance A.
    always @(posedge clk) begin
        pipeA <= memRe ? memWord(memAddr) : 64'hDEAD_BEEF_DEAD_BEEF;
    end
    assign memRdata = pipeA;

    // Memory with 3-cycle read latency for instance B.
    always @(posedge clk) begin
        pipeB[0] <= memReB ? memWord(memAddrB) : 64'hDEAD_BEEF_DEAD_BEEF;
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign memRdataB = pipeB[2];

    // Compare one observed value against its expected value and tally the result.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Start a new cycle just after the rising edge and drive A's inputs for it.
    task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        redirectValid = rv;
        redirectPc    = rpc;
        instrReady    = rdy;
        #1;
    endtask

    // Assert reset mid-cycle so that the outputs can be checked before any clock edge.
    task automatic pulseReset();
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
    endtask

    // Release reset; the cycle that follows is cycle 0.
    task automatic releaseReset(input logic rdy);
        @(posedge clk);
        #1;
        rstN          = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = '0;
        instrReady    = rdy;
        #1;
    endtask

    // Wait a bounded time for the stream to arrive, then expect n consecutive PCs.
    task automatic expectAccepts(input string tag, input logic [63:0] startPc, input int n);
        int waitCnt;
        waitCnt = 0;
        while (!instrValid && waitCnt < 10) begin
            applyStimulus(1'b0, 64'h0, 1'b1);
            waitCnt++;
        end
        checkOutput({tag, "_arrive"}, {63'd0, instrValid}, 64'd1);
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_pc"}, instrValid ? instrPc : 64'hFFFF_FFFF_FFFF_FFFF, startPc + 64'(4 * i));
            checkOutput({tag, "_instr"}, {32'd0, instrA}, {32'd0, expInstr(startPc + 64'(4 * i))});
            applyStimulus(1'b0, 64'h0, 1'b1);
        end
    endtask

    // Bound the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [31:0] firstFour [4];
        logic        sawIssue;
        logic [63:0] w8;

        compared       = 0;
        mismatched     = 0;
        rstN           = 1'b0;
        redirectValid  = 1'b0;
        redirectPc     = '0;
        instrReady     = 1'b1;
        redirectValidB = 1'b0;
        redirectPcB    = '0;
        instrReadyB    = 1'b1;
        firstFour[0]   = 32'h00100093;
        firstFour[1]   = 32'h00200093;
        firstFour[2]   = 32'h00300113;
        firstFour[3]   = 32'h00400193;

        // Reset state
        #2;
        checkOutput("rst_valid", {63'd0, instrValid}, 64'd0);
        checkOutput("rst_memre", {63'd0, memRe}, 64'd0);
        checkOutput("rst_instr", {32'd0, instrA}, 64'd0);
        checkOutput("rst_pc", instrPc, 64'd0);
        checkOutput("rst_count", {61'd0, queueCount}, 64'd0);
        checkOutput("rst_addr", {54'd0, memAddr}, 64'd0);
        checkOutput("rst_countB", {61'd0, queueCountB}, 64'd0);

        // Streaming with ready held high: A at latency 1, B at latency 3
        releaseReset(1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c == 0) begin
                checkOutput("s_memre0", {63'd0, memRe}, 64'd1);
                checkOutput("s_memreB0", {63'd0, memReB}, 64'd1);
            end
            if (c == 1) checkOutput("s_valid1", {63'd0, instrValid}, 64'd0);
            if (c >= 2 && c <= 5) begin
                checkOutput("s_pc", instrValid ? instrPc : 64'hFFFF_FFFF_FFFF_FFFF, 64'(4 * (c - 2)));
                checkOutput("s_instr", {32'd0, instrA}, {32'd0, firstFour[c-2]});
            end
            if (c == 3) checkOutput("latB_valid3", {63'd0, instrValidB}, 64'd0);
            if (c >= 4) begin
                checkOutput("latB_pc", instrValidB ? instrPcB : 64'hFFFF_FFFF_FFFF_FFFF, 64'(4 * (c - 4)));
                checkOutput("latB_instr", {32'd0, instrB}, {32'd0, expInstr(64'(4 * (c - 4)))});
            end
            applyStimulus(1'b0, 64'h0, 1'b1);
        end

        // Asynchronous reset in the middle of the stream
        pulseReset();
        checkOutput("mrst_valid", {63'd0, instrValid}, 64'd0);
        checkOutput("mrst_count", {61'd0, queueCount}, 64'd0);
        checkOutput("mrst_memre", {63'd0, memRe}, 64'd0);
        checkOutput("mrst_addr", {54'd0, memAddr}, 64'd0);
        checkOutput("mrst_instr", {32'd0, instrA}, 64'd0);
        checkOutput("mrst_validB", {63'd0, instrValidB}, 64'd0);

        // Backpressure: ready low for 20 cycles, then drain in order
        releaseReset(1'b0);
        checkOutput("bp_memre0", {63'd0, memRe}, 64'd1);
        sawIssue = 1'b0;
        for (int c = 1; c < 20; c++) begin
            applyStimulus(1'b0, 64'h0, 1'b0);
            if (c >= 5 && memRe) sawIssue = 1'b1;
        end
        checkOutput("bp_count", {61'd0, queueCount}, 64'd4);
        checkOutput("bp_noissue", {63'd0, sawIssue}, 64'd0);
        checkOutput("bp_instr", {32'd0, instrA}, 64'h00100093);
        checkOutput("bp_pc", instrPc, 64'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 64'h0, 1'b1);
            checkOutput("drain_pc", instrValid ? instrPc : 64'hFFFF_FFFF_FFFF_FFFF, 64'(4 * k));
            if (k < 4) checkOutput("drain_instr", {32'd0, instrA}, {32'd0, firstFour[k]});
        end

        // Redirect to 0x40 with 3 queued and 1 in flight
        pulseReset();
        releaseReset(1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0);
        applyStimulus(1'b1, 64'h40, 1'b0);
        checkOutput("rd_count", {61'd0, queueCount}, 64'd3);
        checkOutput("rd_memre", {63'd0, memRe}, 64'd0);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("rd_valid", {63'd0, instrValid}, 64'd0);
        checkOutput("rd_addr", {54'd0, memAddr}, 64'h08);
        checkOutput("rd_memre1", {63'd0, memRe}, 64'd1);
        expectAccepts("redir40", 64'h40, 3);

        // Misaligned target 0x46 behaves as 0x44 (upper half of word 8); the redirect beats a pop
        applyStimulus(1'b1, 64'h46, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("r46_valid", {63'd0, instrValid}, 64'd0);
        expectAccepts("redir46", 64'h44, 2);
        w8 = memWord(10'd8);
        checkOutput("r46_upper", {32'd0, expInstr(64'h44)}, {32'd0, w8[63:32]});

        // Back-to-back redirects: the last target wins
        applyStimulus(1'b1, 64'h100, 1'b1);
        applyStimulus(1'b1, 64'h200, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("b2b_valid", {63'd0, instrValid}, 64'd0);
        expectAccepts("redir200", 64'h200, 3);

        // Memory word address wraps past the top of the 10-bit space
        applyStimulus(1'b1, 64'h1FFC, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("wrap_addr0", {54'd0, memAddr}, 64'h3FF);
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("wrap_addr1", {54'd0, memAddr}, 64'h000);
        expectAccepts("wrap", 64'h1FFC, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
